// File: rtl/assert_track_pkg.sv
// Shared types and defaults for the assertion result tracker.
package assert_track_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_FAIL  = 2'd2,
      ST_ALARM = 2'd3
   } trk_state_t;

   localparam int CNT_W_DEF      = 16;
   localparam int FAIL_LIMIT_DEF = 4;

endpackage

// File: rtl/assert_result_tracker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/assert_result_tracker.sv
// Qualifies checker results, keeps saturating pass/fail totals and raises a sticky
// alarm on a run of FAIL_LIMIT consecutive fails. Macro ASSERT_TRACK_ERR_EN enables
// detection of illegal match==fail samples.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no qualified sample since reset/clear
// ST_PASS  | last qualified sample passed
// ST_FAIL  | last sample failed, streak still below FAIL_LIMIT
// ST_ALARM | streak reached FAIL_LIMIT; absorbing until clr/rst
module assert_result_tracker
   import assert_track_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int FAIL_LIMIT = FAIL_LIMIT_DEF,
   parameter int STRK_W     = $clog2(FAIL_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chk_vld,
   input  logic              match,
   input  logic              fail,
   input  logic              clr,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [STRK_W-1:0] streak,
   output trk_state_t        state,
   output logic              alarm,
   output logic              err
);

   localparam logic [STRK_W-1:0] LIMIT_S = STRK_W'(FAIL_LIMIT);

   logic              w_legal;
   logic              w_err_smp;
   logic              w_take;
   logic              w_pass_smp;
   logic              w_fail_smp;
   logic [STRK_W-1:0] w_streak_inc;

   logic [STRK_W-1:0] r_streak;
   trk_state_t        r_state;
   logic              r_alarm;
   logic              r_err;

`ifdef ASSERT_TRACK_ERR_EN
   assign w_legal   = (match != fail);
   assign w_err_smp = chk_vld & ~w_legal;
`else
   logic w_unused_fail;
   assign w_unused_fail = fail;
   assign w_legal       = 1'b1;
   assign w_err_smp     = 1'b0;
`endif

   // clr drops a coincident sample, so it gates the counter increments too
   assign w_take       = chk_vld & ~clr;
   assign w_pass_smp   = w_take & w_legal & match;
   assign w_fail_smp   = w_take & w_legal & ~match;
   assign w_streak_inc = (r_streak == LIMIT_S) ? r_streak : r_streak + STRK_W'(1);

   sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (w_pass_smp),
      .count (pass_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (w_fail_smp),
      .count (fail_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_streak <= '0;
         r_state  <= ST_IDLE;
         r_alarm  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_pass_smp) begin
            r_streak <= '0;
            if (r_state != ST_ALARM) r_state <= ST_PASS;
         end else if (w_fail_smp) begin
            r_streak <= w_streak_inc;
            // IDLE/PASS always hold streak 0, so one rule covers every non-alarm state
            if (r_state != ST_ALARM) begin
               if (w_streak_inc == LIMIT_S) begin
                  r_state <= ST_ALARM;
                  r_alarm <= 1'b1;
               end else begin
                  r_state <= ST_FAIL;
               end
            end
         end
         if (w_err_smp) r_err <= 1'b1;
      end
   end

   assign streak = r_streak;
   assign state  = r_state;
   assign alarm  = r_alarm;
   assign err    = r_err;

endmodule

// File: doc/assert_result_tracker.md
# assert_result_tracker

Downstream consumer of the immediate-assertion checker's `match`/`fail` pair. Qualifies each result with a sample-valid strobe, keeps saturating pass/fail totals, tracks the run of consecutive failures and raises a sticky alarm when that run reaches a configurable limit. Its registered status outputs feed the test-status/interrupt logic.

## Interface
- `CNT_W`, 16, width of the pass/fail total counters.
- `FAIL_LIMIT`, 4, consecutive qualified failures that trigger the alarm; legal range is 1 to 2^CNT_W−1.
- `STRK_W`, $clog2(FAIL_LIMIT+1), streak width; derived, do not override.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `chk_vld`  in  1  sample-valid: the checker's enable delayed one cycle; results are ignored when 0.
- `match`  in  1  checker pass result.
- `fail`  in  1  checker fail result.
- `clr`  in  1  synchronous clear of counters, streak, alarm and err.
- `pass_cnt`  out  CNT_W  qualified pass total, saturating.
- `fail_cnt`  out  CNT_W  qualified fail total, saturating.
- `streak`  out  STRK_W  current consecutive-fail count, saturating at FAIL_LIMIT.
- `state`  out  2  FSM state, encoded as in the package.
- `alarm`  out  1  sticky; high when `state` is ALARM.
- `err`  out  1  sticky illegal-encoding flag (see Configuration).

## Operation
- Qualified sample: `chk_vld`=1 on a rising edge. When `chk_vld`=0, `match`/`fail` are don't-care and nothing changes.
- Pass sample: `match`=1. Fail sample: `match`=0. `fail` is only checked when ERR_EN is defined.
- Counters: each pass or fail sample adds 1 to its own counter. At 2^CNT_W−1 the counter holds its value and does not wrap.
- Streak:
  - A fail sample increments it, saturating at FAIL_LIMIT.
  - A pass sample resets it to 0.
- FSM:
  - IDLE: no qualified sample since reset/clear. Pass → PASS. Fail → FAIL, or ALARM if FAIL_LIMIT=1.
  - PASS: pass → PASS. Fail → FAIL, or ALARM if FAIL_LIMIT=1.
  - FAIL: pass → PASS. Fail → FAIL until the post-increment streak equals FAIL_LIMIT, then → ALARM.
  - ALARM: absorbing. Only `clr` or `rst` leave it, both to IDLE. Counters keep counting in ALARM. Streak keeps updating, so a pass clears it to 0, but the state stays ALARM.
- `alarm` is 1 exactly when `state` is ALARM.
- `clr`: on the next edge, all counters and streak go to 0, `state` to IDLE, and `alarm`/`err` to 0. A qualified sample in the same cycle as `clr` is dropped.
- `rst` has the same effect as `clr` and has priority over everything. Asserting it mid-stream discards any partial streak.

## Timing
- All outputs are registered.
- A sample qualified at edge N is reflected in every output immediately after edge N (one-cycle latency from the inputs), with no combinational path from inputs to outputs.
- Reset values: `pass_cnt`=0, `fail_cnt`=0, `streak`=0, `state`=IDLE, `alarm`=0, `err`=0.
- Back-to-back qualified samples are accepted every cycle. No stall and no backpressure.
- Priority per edge: `rst` > `clr` > qualified sample.

## Configuration
- Macro `ASSERT_TRACK_ERR_EN`.
- Defined: a qualified sample with `match`==`fail` (both 0 or both 1) is illegal. An illegal sample:
  - sets `err`, which stays high until `clr` or `rst`;
  - is not counted;
  - leaves streak and FSM unchanged.
- Undefined: `err` is tied to 0, `fail` is unused, and every qualified sample is classified by `match` alone.

## Structure
- Package `assert_track_pkg` holds:
  - `typedef enum logic [1:0] {ST_IDLE=0, ST_PASS=1, ST_FAIL=2, ST_ALARM=3} trk_state_t`;
  - default constants `CNT_W_DEF`=16 and `FAIL_LIMIT_DEF`=4.
- Sub-module `sat_counter`: parameter WIDTH; inputs clr and inc; output count. It saturates at all-ones and is instantiated twice, for pass and fail.
- Streak, FSM and err logic live in the top level.

## Test plan
- Reset, then 3 passes with `match`=1, `fail`=0 → `pass_cnt`=3, `fail_cnt`=0, `state`=PASS, `alarm`=0. Each output updates one cycle after its edge.
- FAIL_LIMIT=4: 3 fails, 1 pass, then 4 fails → streak reads 1,2,3,0,1,2,3,4, and `alarm` rises on the 8th sample's edge. A further pass gives `state`=ALARM, streak=0, `pass_cnt`=2.
- `chk_vld`=0 for 10 cycles with random `match`/`fail` → no output changes. `clr` together with a qualified fail → all outputs at reset values and the fail is not counted.
- CNT_W=4: 17 passes → `pass_cnt` is held at 15.
- With `ASSERT_TRACK_ERR_EN`: qualified `match`=1, `fail`=1 → `err`=1 with counters, streak and state unchanged; `clr` → `err`=0. Without the macro, the same stimulus → `pass_cnt`+1 and `err`=0.
- `rst` asserted in FAIL with streak=3 → next cycle all outputs at reset values. A following fail → streak=1, `state`=FAIL.
